// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC rate controller.
// Holds the FSM state encoding, ratio limits and the shift calculation.
package cic_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int MIN_RATIO = 4;
  localparam int SHIFT_W   = 7;
  localparam int SHIFT_MAX = (1 << SHIFT_W) - 1;

  // ceil(log2 r); r <= 1 gives 0
  function automatic logic [4:0] clog2(
    input logic [15:0] r
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      if ((17'd1 << i) < {1'b0, r}) begin
        n = 5'(i + 1);
      end
    end
    return n;
  endfunction

  function automatic logic [SHIFT_W-1:0] shift_of(
    input logic [15:0] r,
    input int          n_stages
  );
    int p;
    p = n_stages * int'(clog2(r));
    if (p > SHIFT_MAX) begin
      return SHIFT_W'(SHIFT_MAX);
    end
    return SHIFT_W'(p);
  endfunction

endpackage

// File: rtl/cic_shift_calc.sv
// Combinational gain-normalisation shift for a CIC decimation ratio.
// Result is N_STAGES*clog2(ratio), saturated to the shift width.
module cic_shift_calc
  import cic_pkg::*;
#(
  parameter int N_STAGES = 5
) (
  input  logic [15:0]        ratio,
  output logic [SHIFT_W-1:0] shift
);

  assign shift = shift_of(ratio, N_STAGES);

endmodule

// File: rtl/cic_rate_ctrl.sv
// CIC decimation-ratio switchover sequencer and output sample stream.
// Define CIC_RATE_CTRL_WARMUP_EN to discard the CIC start-up transient.
module cic_rate_ctrl
  import cic_pkg::*;
#(
  parameter int N_STAGES      = 5,
  parameter int MAX_RATIO     = 16384,
  parameter int DEFAULT_RATIO = 1024,
  parameter int RST_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [15:0]        cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               cic_rst,
  output logic [15:0]        cic_ratio,
  output logic [SHIFT_W-1:0] cic_shift,
  input  logic               cic_strobe,
  input  logic [7:0]         cic_data,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic               busy
);

  localparam logic [SHIFT_W-1:0] RST_SHIFT =
    shift_of(16'(DEFAULT_RATIO), N_STAGES);
  localparam logic [15:0] FLUSH_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] WARM_CNT   = 16'(N_STAGES + 1);

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        ratio_q, ratio_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               strb_q, strb_d;

  logic is_flush, is_warm, is_run;
  logic strb_edge, accept, in_range;

  assign is_flush = (state_q == FLUSH);
  assign is_warm  = (state_q == WARMUP);
  assign is_run   = (state_q == RUN);

  assign strb_edge = cic_strobe & ~strb_q;
  assign accept    = cfg_valid & is_run;
  assign in_range  = (32'(cfg_ratio) >= MIN_RATIO) &&
                     (32'(cfg_ratio) <= MAX_RATIO);

  cic_shift_calc #(
    .N_STAGES (N_STAGES)
  ) u_shift (
    .ratio (ratio_d),
    .shift (shift_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q & ~ovf_clr;
    err_d   = 1'b0;
    // a strobe already high when FLUSH ends must go low before it counts
    strb_d  = cic_strobe | is_flush;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    unique case (1'b1)
      is_flush: begin
        if (cnt_q == FLUSH_LAST) begin
`ifdef CIC_RATE_CTRL_WARMUP_EN
          state_d = WARMUP;
          cnt_d   = WARM_CNT;
`else
          state_d = RUN;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      is_warm: begin
        if (strb_edge) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        if (accept && in_range) begin
          ratio_d = cfg_ratio;
          state_d = FLUSH;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else begin
          err_d = accept;
          if (strb_edge) begin
            if (!valid_q || out_ready) begin
              data_d  = cic_data;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FLUSH;
      cnt_q   <= '0;
      ratio_q <= 16'(DEFAULT_RATIO);
      shift_q <= RST_SHIFT;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  assign cfg_ready = is_run;
  assign cfg_err   = err_q;
  assign cic_rst   = is_flush;
  assign cic_ratio = ratio_q;
  assign cic_shift = shift_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;
  assign busy      = ~is_run;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed self-checking bench for cic_rate_ctrl.
// Warm-up length follows CIC_RATE_CTRL_WARMUP_EN.
module tb_cic_rate_ctrl;

`ifdef CIC_RATE_CTRL_WARMUP_EN
  localparam int WARM = 6;
`else
  localparam int WARM = 0;
`endif
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_ratio = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic        cic_rst;
  logic [15:0] cic_ratio;
  logic [6:0]  cic_shift;
  logic        cic_strobe = 1'b0;
  logic [7:0]  cic_data = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  cic_rate_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cic_rst    (cic_rst),
    .cic_ratio  (cic_ratio),
    .cic_shift  (cic_shift),
    .cic_strobe (cic_strobe),
    .cic_data   (cic_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    cic_strobe = 1'b0;
    step();
    cic_data   = v;
    cic_strobe = 1'b1;
    step();
    cic_strobe = 1'b0;
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (cic_rst && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic warm_pass();
    for (int i = 0; i < WARM; i++) pulse(8'hEE);
  endtask

  task automatic test_reset();
    int n;
    step();
    step();
    n_chk++;
    if ({cic_rst, busy, cfg_ready, cfg_err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rst_ctl got %b want 1100",
               {cic_rst, busy, cfg_ready, cfg_err});
    end
    n_chk++;
    if (cic_ratio !== 16'd1024 || cic_shift !== 7'd50) begin
      n_fail++;
      $display("FAIL rst_ratio got %0d/%0d want 1024/50",
               cic_ratio, cic_shift);
    end
    n_chk++;
    if ({out_valid, out_data, ovf} !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_out got v%b d%h o%b want 0",
               out_valid, out_data, ovf);
    end
    rst = 1'b1;
    wait_flush(n);
    n_chk++;
    if (n !== RSTC) begin
      n_fail++;
      $display("FAIL rst_flush got %0d want %0d", n, RSTC);
    end
    for (int i = 0; i < WARM; i++) begin
      pulse(8'(i));
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL warm_discard %0d got %b want 0",
                 i, out_valid);
      end
    end
    n_chk++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry got b%b r%b want b0 r1",
               busy, cfg_ready);
    end
    pulse(8'h5A);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL first_sample got %b/%h want 1/5a",
               out_valid, out_data);
    end
  endtask

  task automatic test_cfg_change();
    int n;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL consume got %b want 0", out_valid);
    end
    cfg_valid = 1'b1;
    cfg_ratio = 16'd64;
    step();
    cfg_valid = 1'b0;
    n_chk++;
    if (cic_ratio !== 16'd64 || cic_shift !== 7'd30) begin
      n_fail++;
      $display("FAIL cfg64 got %0d/%0d want 64/30",
               cic_ratio, cic_shift);
    end
    n_chk++;
    if ({cic_rst, busy, cfg_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL cfg64_ctl got %b want 110",
               {cic_rst, busy, cfg_ready});
    end
    wait_flush(n);
    n_chk++;
    if (n !== RSTC) begin
      n_fail++;
      $display("FAIL cfg64_flush got %0d want %0d", n, RSTC);
    end
    for (int i = 0; i < WARM; i++) begin
      n_chk++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL warm_busy %0d got %b want 1", i, busy);
      end
      pulse(8'hEE);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg64_run got %b want 0", busy);
    end
    pulse(8'hA5);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL cfg64_sample got %b/%h want 1/a5",
               out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_cfg_err();
    logic [15:0] bad [3];
    bad[0] = 16'd3;
    bad[1] = 16'd20000;
    bad[2] = 16'd16385;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_ratio = bad[i];
      step();
      cfg_valid = 1'b0;
      n_chk++;
      if ({cfg_err, busy, cic_rst} !== 3'b100) begin
        n_fail++;
        $display("FAIL err_%0d got %b want 100",
                 bad[i], {cfg_err, busy, cic_rst});
      end
      n_chk++;
      if (cic_ratio !== 16'd64 || cic_shift !== 7'd30) begin
        n_fail++;
        $display("FAIL err_keep_%0d got %0d/%0d want 64/30",
                 bad[i], cic_ratio, cic_shift);
      end
      step();
      n_chk++;
      if (cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse_%0d got %b want 0",
                 bad[i], cfg_err);
      end
    end
  endtask

  task automatic test_bounds();
    int n;
    logic [15:0] r [2];
    logic [6:0]  s [2];
    r[0] = 16'd16384;
    s[0] = 7'd70;
    r[1] = 16'd4;
    s[1] = 7'd10;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1;
      cfg_ratio = r[i];
      step();
      cfg_valid = 1'b0;
      n_chk++;
      if (cic_ratio !== r[i] || cic_shift !== s[i] ||
          cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL bound got %0d/%0d e%b want %0d/%0d e0",
                 cic_ratio, cic_shift, cfg_err, r[i], s[i]);
      end
      wait_flush(n);
      warm_pass();
    end
  endtask

  task automatic test_ovf();
    pulse(8'h11);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_first got %b/%h o%b want 1/11 o0",
               out_valid, out_data, ovf);
    end
    pulse(8'h22);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold got %b/%h o%b want 1/11 o1",
               out_valid, out_data, ovf);
    end
    ovf_clr = 1'b1;
    pulse(8'h33);
    n_chk++;
    if (ovf !== 1'b1 || out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL ovf_setwins got o%b d%h want o1 d11",
               ovf, out_data);
    end
    step();
    ovf_clr = 1'b0;
    n_chk++;
    if (ovf !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clr got o%b v%b want o0 v1", ovf, out_valid);
    end
  endtask

  task automatic test_cfg_with_strobe();
    int n;
    cic_strobe = 1'b0;
    step();
    cfg_valid  = 1'b1;
    cfg_ratio  = 16'd1024;
    cic_strobe = 1'b1;
    cic_data   = 8'h77;
    step();
    cfg_valid  = 1'b0;
    cic_strobe = 1'b0;
    n_chk++;
    if ({out_valid, ovf, cic_rst} !== 3'b001) begin
      n_fail++;
      $display("FAIL cfg_strb got v%b o%b r%b want v0 o0 r1",
               out_valid, ovf, cic_rst);
    end
    n_chk++;
    if (cic_ratio !== 16'd1024 || cic_shift !== 7'd50) begin
      n_fail++;
      $display("FAIL cfg_strb_ratio got %0d/%0d want 1024/50",
               cic_ratio, cic_shift);
    end
    cic_strobe = 1'b1;
    wait_flush(n);
    step();
    n_chk++;
    if (out_valid !== 1'b0 || busy !== (WARM > 0)) begin
      n_fail++;
      $display("FAIL strb_high_entry got v%b b%b want v0 b%0d",
               out_valid, busy, WARM > 0);
    end
    warm_pass();
  endtask

  task automatic test_reset_mid();
    int n;
    cfg_valid = 1'b1;
    cfg_ratio = 16'd64;
    step();
    cfg_valid = 1'b0;
    wait_flush(n);
    if (WARM > 0) pulse(8'hEE);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({cic_rst, busy, cfg_ready, out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_rst_ctl got %b want 1100",
               {cic_rst, busy, cfg_ready, out_valid});
    end
    n_chk++;
    if (cic_ratio !== 16'd1024 || cic_shift !== 7'd50) begin
      n_fail++;
      $display("FAIL mid_rst_ratio got %0d/%0d want 1024/50",
               cic_ratio, cic_shift);
    end
    step();
    rst = 1'b1;
    wait_flush(n);
    n_chk++;
    if (n !== RSTC) begin
      n_fail++;
      $display("FAIL mid_rst_flush got %0d want %0d", n, RSTC);
    end
    warm_pass();
    pulse(8'h3C);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C ||
        cic_ratio !== 16'd1024) begin
      n_fail++;
      $display("FAIL mid_rst_sample got %b/%h r%0d want 1/3c r1024",
               out_valid, out_data, cic_ratio);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_change();
    test_cfg_err();
    test_bounds();
    test_ovf();
    test_cfg_with_strobe();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
